// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared CPU definitions: fetch FSM states, reset/NOP defaults, opcodes
package cpu_defs_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Instruction memory is word addressed; low address bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory req/ack bus between fetch and imem
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - two-entry {instr, pc} output + skid buffer with load/consume/flush
module fetch_skid_buf
    import cpu_defs_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        load_i,
    input  logic [31:0] load_instr_i,
    input  logic [31:0] load_pc_i,
    input  logic        consume_i,
    output logic        out_valid_o,
    output logic [31:0] out_instr_o,
    output logic [31:0] out_pc_o,
    output logic [31:0] out_pc4_o,
    output logic        skid_valid_o
);

    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_pc4_q, out_pc4_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;

    // Next buffer contents: flush wins, otherwise drain skid on consume then place new data
    always_comb begin
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;
        out_pc4_d    = out_pc4_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (consume_i) begin
                if (skid_valid_q) begin
                    out_instr_d  = skid_instr_q;
                    out_pc_d     = skid_pc_q;
                    out_pc4_d    = skid_pc_q + 32'd4;
                    skid_valid_d = 1'b0;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
            if (load_i) begin
                if (!out_valid_d) begin
                    out_valid_d = 1'b1;
                    out_instr_d = load_instr_i;
                    out_pc_d    = load_pc_i;
                    out_pc4_d   = load_pc_i + 32'd4;
                end else begin
                    skid_valid_d = 1'b1;
                    skid_instr_d = load_instr_i;
                    skid_pc_d    = load_pc_i;
                end
            end
        end
    end

    // Buffer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_instr_q  <= NOP_INSTR;
            out_pc_q     <= 32'd0;
            out_pc4_q    <= 32'd0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= 32'd0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
            out_pc4_q    <= out_pc4_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign out_instr_o  = out_valid_q ? out_instr_q : NOP_INSTR;
    assign out_pc_o     = out_pc_q;
    assign out_pc4_o    = out_pc4_q;
    assign skid_valid_o = skid_valid_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, imem req/ack FSM, redirects, skid buffer; FETCH_PERF_CNT_EN adds counters
module fetch_stage
    import cpu_defs_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master imem,
    input  logic          stall,
    input  logic          branch_taken,
    input  logic [31:0]   branch_target,
    input  logic          jump,
    input  logic [31:0]   jump_target,
    output logic [31:0]   instr_o,
    output logic [31:0]   pc_o,
    output logic [31:0]   pc_plus4_o,
    output logic          instr_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]   fetch_cnt,
    output logic [31:0]   discard_cnt
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  addr_q, addr_d;
    logic         discard_q, discard_d;

    logic         redirect;
    logic [31:0]  redirect_target;
    logic         ack_fire;
    logic         accept;
    logic         consume;
    logic         out_valid;
    logic         skid_valid;
    logic         skid_full_next;

    assign redirect        = branch_taken | jump;
    assign redirect_target = word_align(branch_taken ? branch_target : jump_target);
    assign ack_fire        = (state_q == S_REQ) && imem.imem_ack;
    // Data is kept only for an in-order request that is neither stale nor hit by a redirect.
    assign accept          = ack_fire && !discard_q && !redirect;
    assign consume         = out_valid && !stall;
    assign skid_full_next  = !redirect && !consume && (skid_valid || (accept && out_valid));

    fetch_skid_buf #(
        .NOP_INSTR (NOP_INSTR)
    ) u_skid (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (redirect),
        .load_i       (accept),
        .load_instr_i (imem.imem_rdata),
        .load_pc_i    (addr_q),
        .consume_i    (consume),
        .out_valid_o  (out_valid),
        .out_instr_o  (instr_o),
        .out_pc_o     (pc_o),
        .out_pc4_o    (pc_plus4_o),
        .skid_valid_o (skid_valid)
    );

    assign instr_valid = out_valid;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: pause requesting while the skid holds an entry
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_REQ;
            S_REQ:   if (ack_fire && skid_full_next) state_d = S_WAIT;
            S_WAIT:  if (!skid_full_next) state_d = S_REQ;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        imem.imem_req = (state_q == S_REQ);
    end

    assign imem.imem_addr = addr_q;

    // Next PC: redirect beats sequential advance
    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = redirect_target;
        end else if (accept) begin
            pc_d = pc_q + 32'd4;
        end
    end

    // Request address frozen while a request is outstanding; discard marks a stale in-flight request
    always_comb begin
        addr_d    = ((state_q == S_REQ) && !ack_fire) ? addr_q : pc_d;
        discard_d = discard_q;
        if (ack_fire) begin
            discard_d = 1'b0;
        end else if ((state_q == S_REQ) && redirect) begin
            discard_d = 1'b1;
        end
    end

    // PC, request address and discard registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            addr_q    <= RESET_PC;
            discard_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            discard_q <= discard_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, discard_cnt_q;
    logic [1:0]  drop_cnt;

    // Dropped ack plus every valid entry a redirect throws away (a consumed entry is not a drop)
    assign drop_cnt = {1'b0, ack_fire && (discard_q || redirect)}
                    + {1'b0, redirect && out_valid && !consume}
                    + {1'b0, redirect && skid_valid};

    // Performance counters, free-running with wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q   <= 32'd0;
            discard_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q   <= fetch_cnt_q + {31'd0, consume};
            discard_cnt_q <= discard_cnt_q + {30'd0, drop_cnt};
        end
    end

    assign fetch_cnt   = fetch_cnt_q;
    assign discard_cnt = discard_cnt_q;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the main control decoder.
- Owns the PC and issues word requests to instruction memory over a req/ack handshake.
- Presents the fetched instruction, with its PC and PC+4, to decode; the decoder reads bits [31:26] as the opcode.
- Accepts branch/jump redirects from downstream. A 2-entry buffer (output + skid) absorbs decode stalls.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0000, value driven on instr_o when no valid instruction

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request; held until imem_ack
imem_addr  out  32  word address, stable while imem_req=1
imem_ack  in  1  request completes at this edge; imem_rdata valid
imem_rdata  in  32  instruction word
stall  in  1  decode cannot accept this cycle
branch_taken  in  1  redirect to branch_target (branch & zero)
branch_target  in  32  branch destination
jump  in  1  redirect to jump_target
jump_target  in  32  jump destination
instr_o  out  32  instruction to decode
pc_o  out  32  PC of instr_o
pc_plus4_o  out  32  pc_o + 4
instr_valid  out  1  instr_o is valid

Behaviour:
- Reset (async, immediate):
  - pc_q=RESET_PC; imem_req=0; instr_valid=0; instr_o=NOP_INSTR; pc_o=0; pc_plus4_o=0.
  - Skid empty; discard=0; state=S_IDLE.
- States:
  - S_IDLE: first cycle after reset release; go to S_REQ.
  - S_REQ: imem_req=1, imem_addr=pc_q.
  - S_WAIT: skid full, no request in flight.
- Handshake:
  - At most one outstanding request.
  - imem_req and imem_addr stay constant until the edge where imem_ack=1.
  - Zero-wait ack (ack in the first cycle of req) is legal.
- Consume: an instruction is consumed at any edge with instr_valid=1 and stall=0.
- On a completing ack with no discard:
  - Data goes to the output register if it is empty or being consumed this edge. Otherwise it goes to skid.
  - pc_q <= pc_q + 4 (32-bit wrap; 32'hFFFF_FFFC -> 0).
- Next-request rule:
  - A new request starts only if skid will be empty after this edge.
  - Otherwise go to S_WAIT, imem_req=0.
- Skid drain: when output is consumed and skid is full, skid moves to output, skid empties, then S_WAIT -> S_REQ.
- Throughput: one instruction per cycle with zero-wait memory and stall=0. Latency from ack edge to instr_valid is 1 edge.
- Redirect (branch_taken | jump, sampled at edge):
  - branch_taken has priority over jump.
  - Output and skid are invalidated; instr_o=NOP_INSTR.
  - pc_q <= target.
  - If a request is in flight and not acking this edge: discard=1. The in-flight request completes at its original address, the data is dropped, then S_REQ at target.
  - If ack coincides with redirect: data is dropped, discard stays 0, and the next cycle requests target.
  - Redirect overrides stall.
- Redirect while discard=1: target updates and discard remains set; only one drop occurs.
- Misaligned targets: bits [1:0] are forced to 0.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, adds outputs fetch_cnt[31:0] and discard_cnt[31:0]. Both reset to 0.
  - fetch_cnt increments on each instruction consumed by decode.
  - discard_cnt increments on each dropped ack and each flushed valid entry. A flush of output+skid counts 2.
  - Both wrap at 2^32.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package cpu_defs_pkg holds:
  - state enum (S_IDLE, S_REQ, S_WAIT);
  - NOP_INSTR;
  - RESET_PC default;
  - opcode constants (R-type 6'b000000, lw 6'b100011, sw 6'b101011, beq 6'b000100, addi 6'b001000, j 6'b000010).
- Sub-module fetch_skid_buf: 2-entry {instr, pc} buffer with load/consume/flush; the top level holds the FSM, PC and discard logic.

Test Plan:
- Reset release, zero-wait ack, stall=0, imem returns 32'h2008_0005, 32'h8C09_0000, ... -> imem_addr 0,4,8,... one per cycle; instr_o follows 1 edge later; pc_o 0,4,8; pc_plus4_o 4,8,12.
- stall held high 5 cycles with zero-wait memory -> exactly 2 instructions buffered, imem_req low after 2nd ack; on stall release instructions emerge in order with no loss or duplication.
- Ack delayed 3 cycles, branch_taken=1 with branch_target=32'h40 in cycle 1 of wait -> imem_addr stays at old PC until ack, data dropped, next request addr 32'h40, first valid pc_o=32'h40.
- jump=1 with jump_target=32'h100 on the same edge as ack -> acked word never valid; next imem_addr=32'h100.
- branch_taken=1 (target 32'h20) and jump=1 (target 32'h80) together -> next fetch 32'h20.
- rst_n low while imem_req=1 and skid full -> imem_req and instr_valid drop immediately; after release, fetch restarts at RESET_PC; with FETCH_PERF_CNT_EN counters read 0.
